epochtv1_scandoubler: RTL

- Sits directly downstream of the epochtv1 video output. Consumes its CE-qualified DE/HS/VS/RGB stream at 15.7 kHz line rate.
- Emits each scanline twice at double pixel rate, giving 31.4 kHz output for VGA-class displays and the video framework.
- Ping-pong line buffer: the input line n is written while line n-1 is read out twice.
- Output timing (HS width, DE start, DE length, line period) is measured from the input, so no fixed geometry is hard-coded.

---
 rtl/scv_video_pkg.sv | 20 ++
 rtl/dpram.sv | 21 ++
 rtl/epochtv1_scandoubler.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/scv_video_pkg.sv
// Shared types and constants for the epochtv1 video path scan doubler.
package scv_video_pkg;

  typedef logic [23:0] rgb_t;

  localparam int CW_DEF    = 10;

  // Output strobe cadence: first pulse 3 clks after a line event, then 4,3,4,3...
  localparam int CAD_FIRST = 3;
  localparam int CAD_LONG  = 4;
  localparam int CAD_SHORT = 3;

  typedef enum logic [1:0] {
    PB_IDLE  = 2'd0,
    PB_COPY0 = 2'd1,
    PB_COPY1 = 2'd2,
    PB_DONE  = 2'd3
  } pb_state_t;

endpackage

// File: rtl/dpram.sv
// Simple dual-port RAM: port 1 writes, port 2 reads with one clock of latency.
module dpram #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8
) (
  input  logic              i_clk,
  input  logic              i_we1,
  input  logic [AWIDTH-1:0] i_addr1,
  input  logic [DWIDTH-1:0] i_din1,
  input  logic [AWIDTH-1:0] i_addr2,
  output logic [DWIDTH-1:0] o_dout2
);

  logic [DWIDTH-1:0] r_mem [0:(1<<AWIDTH)-1];

  always_ff @(posedge i_clk) begin
    if (i_we1) r_mem[i_addr1] <= i_din1;
    o_dout2 <= r_mem[i_addr2];
  end

endmodule

// File: rtl/epochtv1_scandoubler.sv
// Line-doubling scan converter: measures input line geometry and replays each
// stored line twice at double pixel rate from a ping-pong line buffer.
module epochtv1_scandoubler
  import scv_video_pkg::*;
#(
  parameter int MAX_W = 256,
  parameter int CW    = CW_DEF
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        CE,
  input  logic        DE,
  input  logic        HS,
  input  logic        VS,
  input  logic [23:0] RGB,
  output logic        CE_OUT,
  output logic        DE_OUT,
  output logic        HS_OUT,
  output logic        VS_OUT,
  output logic [23:0] RGB_OUT,
  output logic [1:0]  DBG_PB_STATE
);

  localparam int XW = $clog2(MAX_W);
  localparam int AW = XW + 1;
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [XW:0]   WMAX = (XW+1)'(MAX_W);

  logic          r_hs_prev, r_de_prev, r_bank, r_seen, r_de_seen, r_vs_l;
  logic [XW:0]   r_wr_x, r_len;
  logic [CW-1:0] r_cnt_in, r_de_start_in, r_hs_w_in;
  logic [CW-1:0] r_period, r_hs_w, r_de_start, r_oh;
  logic [2:0]    r_cad;
  logic          r_alt;
  pb_state_t     r_state, w_state_nx;

  logic [CW-1:0] w_pos;
  logic [XW-1:0] w_rel;
  logic          w_line, w_we, w_tick, w_last, w_emit, w_active, w_hs, w_de;
  rgb_t          w_q;

  // Position of the current CE within the line, counting the HS-rise CE as 0.
  assign w_pos  = (r_cnt_in == CMAX) ? CMAX : r_cnt_in + CW'(1);
  assign w_line = CE & HS & ~r_hs_prev;
  assign w_we   = CE & DE & (r_wr_x < WMAX);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_hs_prev     <= 1'b0;
      r_de_prev     <= 1'b0;
      r_bank        <= 1'b0;
      r_seen        <= 1'b0;
      r_de_seen     <= 1'b0;
      r_vs_l        <= 1'b0;
      r_wr_x        <= '0;
      r_len         <= '0;
      r_cnt_in      <= '0;
      r_de_start_in <= '0;
      r_hs_w_in     <= '0;
      r_period      <= '0;
      r_hs_w        <= '0;
      r_de_start    <= '0;
    end else if (CE) begin
      r_hs_prev <= HS;
      r_de_prev <= DE;
      if (w_line) begin
        r_period      <= w_pos;
        r_len         <= r_wr_x;
        r_hs_w        <= r_hs_w_in;
        r_de_start    <= r_de_start_in;
        r_vs_l        <= VS;
        r_bank        <= ~r_bank;
        r_wr_x        <= '0;
        r_cnt_in      <= '0;
        r_seen        <= 1'b1;
        r_hs_w_in     <= '0;
        r_de_start_in <= '0;
        r_de_seen     <= DE & ~r_de_prev;
      end else begin
        r_cnt_in <= w_pos;
        if (w_we) r_wr_x <= r_wr_x + (XW+1)'(1);
        if (DE && !r_de_prev && !r_de_seen) begin
          r_de_start_in <= w_pos;
          r_de_seen     <= 1'b1;
        end
        if (!HS && r_hs_prev) r_hs_w_in <= w_pos;
      end
    end
  end

  // Playback strobe: a line event resynchronises the cadence to the input.
  assign w_tick = (r_cad == 3'd0);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cad <= '0;
      r_alt <= 1'b0;
    end else if (w_line) begin
      r_cad <= 3'(CAD_FIRST - 1);
      r_alt <= 1'b0;
    end else if (w_tick) begin
      r_cad <= r_alt ? 3'(CAD_SHORT - 1) : 3'(CAD_LONG - 1);
      r_alt <= ~r_alt;
    end else begin
      r_cad <= r_cad - 3'd1;
    end
  end

  assign w_last = (r_oh >= r_period - CW'(1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= PB_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (w_line) begin
      w_state_nx = r_seen ? PB_COPY0 : PB_IDLE;
    end else if (w_tick && w_last) begin
      case (r_state)
        PB_COPY0: w_state_nx = PB_COPY1;
        PB_COPY1: w_state_nx = PB_DONE;
        default:  w_state_nx = r_state;
      endcase
    end
  end

  always_comb begin
    w_active = w_tick && (r_state != PB_IDLE);
    w_emit   = w_tick && ((r_state == PB_COPY0) || (r_state == PB_COPY1));
  end

  assign DBG_PB_STATE = r_state;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)       r_oh <= '0;
    else if (w_line) r_oh <= '0;
    else if (w_emit) begin
      if (!w_last)                     r_oh <= r_oh + CW'(1);
      else if (r_state == PB_COPY0)    r_oh <= '0;
    end
  end

  assign w_hs  = (r_oh < r_hs_w);
  assign w_de  = ({1'b0, r_oh} >= {1'b0, r_de_start}) &&
                 ({1'b0, r_oh} <  ({1'b0, r_de_start} + (CW+1)'(r_len)));
  assign w_rel = XW'(r_oh - r_de_start);

  // Read address follows r_oh, which only moves on ticks, so RAM data is
  // settled by the next tick.
  dpram #(
    .DWIDTH (24),
    .AWIDTH (AW)
  ) u_line_buf (
    .i_clk   (CLK),
    .i_we1   (w_we),
    .i_addr1 ({r_bank, r_wr_x[XW-1:0]}),
    .i_din1  (RGB),
    .i_addr2 ({~r_bank, w_rel}),
    .o_dout2 (w_q)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      CE_OUT  <= 1'b0;
      DE_OUT  <= 1'b0;
      HS_OUT  <= 1'b0;
      VS_OUT  <= 1'b0;
      RGB_OUT <= '0;
    end else begin
      CE_OUT <= w_active;
      if (w_active) begin
        HS_OUT  <= w_emit & w_hs;
        DE_OUT  <= w_emit & w_de;
        VS_OUT  <= w_emit & r_vs_l;
        RGB_OUT <= (w_emit && w_de) ? w_q : '0;
      end
    end
  end

endmodule
